qed_dup_scheduler: RTL
======================

QED_DUP_SCHEDULER -- requirements
Module: qed_dup_scheduler

Interface
REQ-001 Parameter: DEPTH, 16, original-instruction queue depth; power of 2, range 2..64.
REQ-002 Parameter: CNT_W, 16, width of the original and duplicate commit counters.
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-005 Port: ena  in  1  pipeline advance; when low the block SHALL hold all state and outputs.
REQ-006 Port: exec_dup  in  1  free input from the formal tool requesting the switch to duplicate mode.
REQ-007 Port: ifu_qed_instruction  in  32  candidate instruction from the formal tool.
REQ-008 Port: qed_instruction  out  32  registered instruction issued to the core.
REQ-009 Port: qed_vld_out  out  1  high when qed_instruction is a non-NOP.
REQ-010 Port: qed_dup_mode  out  1  high while in the DUP state.
REQ-011 Port: qed_ready  out  1  original and duplicate streams are balanced.

Function
REQ-012 The NOP encoding SHALL be 32'h0000007F (opcode 7'b1111111).
REQ-013 The FSM SHALL have exactly two states: ORIG and DUP.
REQ-014 All actions SHALL occur only in cycles with ena=1.
REQ-015 ORIG, non-NOP input, queue not full: push the input, issue it unchanged next cycle, and increment orig_cnt.
REQ-016 ORIG, NOP input: issue NOP with no push.
REQ-017 ORIG, queue full: issue NOP, drop the input, and enter DUP.
REQ-018 ORIG, exec_dup=1 with queue non-empty: enter DUP, and the current input SHALL still be processed per REQ-015/016 in that cycle.
REQ-019 ORIG, exec_dup=1 with queue empty: no transition.
REQ-020 DUP: pop one entry per cycle, issue its remapped form, increment dup_cnt, and ignore ifu_qed_instruction.
REQ-021 DUP: the pop that empties the queue SHALL return the FSM to ORIG on the same edge.
REQ-022 Remap, R-type (opcode 0110011): set bit 4 of rd, rs1 and rs2.
REQ-023 Remap, I-type (opcode 0010011): set bit 4 of rd and rs1; immediate and shamt unchanged.
REQ-024 Remap, LW (opcode 0000011): set bit 4 of rd and set imm12 bit 6 (+64); rs1 unchanged.
REQ-025 Remap, SW (opcode 0100011): set bit 4 of rs2 and set instruction bit 26 (imm7 bit 1, +64 bytes); rs1 unchanged.
REQ-026 Remap, any other opcode: pass the instruction unchanged.
REQ-027 Instruction latency SHALL be exactly 1 cycle from the accepting edge to qed_instruction.
REQ-028 Both counters SHALL wrap modulo 2^CNT_W.
REQ-029 qed_ready SHALL be registered and equal (state==ORIG && queue empty && orig_cnt==dup_cnt && orig_cnt!=0).
REQ-030 Push and pop SHALL never occur in the same cycle.
REQ-031 Queue order SHALL be strict FIFO.

Reset
REQ-032 rst_n=0 at a rising edge SHALL set: state ORIG, queue empty, both counters 0, qed_instruction=32'h0000007F, qed_vld_out=0, qed_dup_mode=0, qed_ready=0.
REQ-033 Reset SHALL override ena and take effect mid-DUP; queued entries are discarded.

Structure
REQ-034 Package qed_pkg SHALL hold the opcode constants, the NOP constant, the state enum and the remap bit positions.
REQ-035 Sub-module qed_fifo SHALL implement the synchronous FIFO (push, pop, full, empty, DEPTH parameter), reset by rst_n.
REQ-036 Remap SHALL be a pure function located in qed_pkg.

Verification
REQ-037 Scenario: ADD 0x003100B3 in ORIG, then exec_dup.
- Response: 0x003100B3 issued, then 0x013908B3 issued in DUP.
- qed_ready=1 one cycle after return to ORIG, with both counters at 1.
REQ-038 Scenario: LW 0x00802283 and SW 0x00302223 in ORIG, then exec_dup.
- Response: duplicates 0x04802A83 then 0x05302223, in that order.
REQ-039 Scenario: DEPTH=16 with 17 consecutive non-NOPs.
- Response: 16 pushed, the 17th dropped with NOP issued.
- Forced DUP, then 16 remapped issues, then ORIG.
REQ-040 Scenario: exec_dup=1 with queue empty and a NOP input.
- Response: stays ORIG, NOP issued, qed_ready=0.
REQ-041 Scenario: ena=0 for 3 cycles mid-DUP.
- Response: outputs, queue and counters frozen; resumes identically when ena=1.
REQ-042 Scenario: rst_n=0 mid-DUP with 5 entries queued.
- Response: next cycle ORIG, NOP output, counters 0, qed_ready=0.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared constants, state type and duplicate-remap function for
// the QED duplicate scheduler: opcodes, NOP word, remap bit positions.
package qed_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_NOP = 7'b1111111;

    localparam logic [31:0] NOP_INSTR = 32'h0000007F;

    // Bit 4 of each register field, and the +64 offset bit.
    localparam int RD_B4  = 11;
    localparam int RS1_B4 = 19;
    localparam int RS2_B4 = 24;
    localparam int OFF_64 = 26;

    typedef enum logic {
        ORIG = 1'b0,
        DUP  = 1'b1
    } qed_state_e;

    function automatic logic is_nop(input logic [31:0] ins);
        return ins[6:0] == OP_NOP;
    endfunction

    // Duplicates use the upper register half and a shifted
    // memory window so they never alias the originals.
    function automatic logic [31:0] qed_remap(
        input logic [31:0] ins
    );
        logic [31:0] r;
        r = ins;
        case (ins[6:0])
            OP_R: begin
                r[RD_B4]  = 1'b1;
                r[RS1_B4] = 1'b1;
                r[RS2_B4] = 1'b1;
            end
            OP_I: begin
                r[RD_B4]  = 1'b1;
                r[RS1_B4] = 1'b1;
            end
            OP_LW: begin
                r[RD_B4]  = 1'b1;
                r[OFF_64] = 1'b1;
            end
            OP_SW: begin
                r[RS2_B4] = 1'b1;
                r[OFF_64] = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qed_fifo.sv
// Synchronous FIFO of original instructions awaiting duplication.
// Ports: clk, rst_n, push/wdata, pop/rdata, full, empty, count.
module qed_fifo
    import qed_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [31:0]                wdata,
    input  logic                       pop,
    output logic [31:0]                rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/qed_dup_scheduler.sv
// QED scheduler: issues originals, then their remapped duplicates.
// Ports: clk, rst_n, ena, exec_dup, ifu_qed_instruction in;
// qed_instruction, qed_vld_out, qed_dup_mode, qed_ready out.
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        exec_dup,
    input  logic [31:0] ifu_qed_instruction,
    output logic [31:0] qed_instruction,
    output logic        qed_vld_out,
    output logic        qed_dup_mode,
    output logic        qed_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    qed_state_e       state_q, state_d;
    logic [CNT_W-1:0] orig_cnt, orig_d;
    logic [CNT_W-1:0] dup_cnt, dup_d;
    logic [31:0]      instr_q, instr_d;
    logic             vld_q, vld_d;
    logic             ready_q, ready_d;

    logic             push, pop;
    logic             full, empty;
    logic [CW-1:0]    count;
    logic [31:0]      head;

    qed_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .wdata(ifu_qed_instruction),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ORIG;
            orig_cnt <= '0;
            dup_cnt  <= '0;
            instr_q  <= NOP_INSTR;
            vld_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            orig_cnt <= orig_d;
            dup_cnt  <= dup_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        orig_d  = orig_cnt;
        dup_d   = dup_cnt;
        instr_d = instr_q;
        vld_d   = vld_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (ena) begin
            unique case (state_q)
                ORIG: begin
                    if (full) begin
                        // No room: drop input, drain the queue.
                        instr_d = NOP_INSTR;
                        vld_d   = 1'b0;
                        state_d = DUP;
                    end else begin
                        if (is_nop(ifu_qed_instruction)) begin
                            instr_d = NOP_INSTR;
                            vld_d   = 1'b0;
                        end else begin
                            push    = 1'b1;
                            instr_d = ifu_qed_instruction;
                            vld_d   = 1'b1;
                            orig_d  = orig_cnt + CNT_ONE;
                        end
                        // Occupancy before this cycle's push decides.
                        if (exec_dup && !empty) state_d = DUP;
                    end
                end
                DUP: begin
                    if (empty) begin
                        instr_d = NOP_INSTR;
                        vld_d   = 1'b0;
                        state_d = ORIG;
                    end else begin
                        pop     = 1'b1;
                        instr_d = qed_remap(head);
                        vld_d   = 1'b1;
                        dup_d   = dup_cnt + CNT_ONE;
                        if (count == CW'(1)) state_d = ORIG;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sampled from current state, so it rises one cycle
    // after the final duplicate returns the FSM to ORIG.
    always_comb begin
        ready_d = (state_q == ORIG) && empty &&
                  (orig_cnt == dup_cnt) && (orig_cnt != '0);
    end

    assign qed_instruction = instr_q;
    assign qed_vld_out     = vld_q;
    assign qed_dup_mode    = (state_q == DUP);
    assign qed_ready       = ready_q;

endmodule
